// File: rtl/multdiv_seq_pkg.sv
// Shared constants, state encoding and helpers for the sequential multiply/divide unit.
package multdiv_seq_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned ACC_W      = 2 * WIDTH;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = 6;

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Operation latched at start: divide select and sign of the final result.
    typedef struct packed {
        logic div;
        logic neg;
    } op_ctrl_t;

    // Unsigned magnitude of a two's complement word; INT_MIN maps to 2^31.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// 33-bit add/subtract step shared by shift-add multiply and restoring divide.
module multdiv_addsub
    import multdiv_seq_pkg::*;
(
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] result_c
);

    // Subtract is a + ~b + 1: invert b and feed sub in as the carry.
    assign result_c = a + (b ^ {(WIDTH + 1){sub}}) + (WIDTH + 1)'(sub);

endmodule

// File: rtl/multdiv_seq.sv
// Iterative 32-bit signed multiply/divide engine with start / ready / exception handshake.
module multdiv_seq
    import multdiv_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_e           state, state_next;
    op_ctrl_t         op;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] addend;
    logic [ACC_W-1:0] acc;
    logic             dz_pend;
    logic             accept;

    logic             start_req, start_div, start_dz;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH:0]   shifted, add_a, step;
    logic [ACC_W-1:0] acc_step, prod_signed;
    logic [WIDTH-1:0] quot_signed, fix_result;
    logic             fix_exc;

    assign start_req = ctrl_MULT | ctrl_DIV;
    assign start_div = ~ctrl_MULT;
    assign start_dz  = start_div && (data_operandB == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Divide-by-zero waits one cycle in IDLE (dz_pend) and then reports from DONE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept = start_req && !dz_pend;
                if (dz_pend)     state_next = DONE;
                else if (accept) state_next = start_dz ? IDLE : RUN;
            end
            RUN: begin
                if (cnt == CNT_W'(ITER_COUNT)) state_next = FIX;
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                accept     = start_req;
                state_next = accept ? (start_dz ? IDLE : RUN) : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One iteration: acc = {partial/remainder, multiplier/quotient bits}.
    assign hi      = acc[ACC_W-1:WIDTH];
    assign lo      = acc[WIDTH-1:0];
    assign shifted = {hi, lo[WIDTH-1]};
    assign add_a   = op.div ? shifted : {1'b0, hi};

    multdiv_addsub u_addsub (
        .a        (add_a),
        .b        ({1'b0, addend}),
        .sub      (op.div),
        .result_c (step)
    );

    always_comb begin
        if (op.div) begin
            acc_step = step[WIDTH] ? {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
                                   : {step[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = lo[0] ? {step, lo[WIDTH-1:1]}
                             : {1'b0, hi, lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up and overflow detection; only INT_MIN / -1 yields an unsigned quotient of 2^31 with positive sign.
    always_comb begin
        prod_signed = op.neg ? -acc : acc;
        quot_signed = op.neg ? -lo : lo;
        if (op.div) begin
            fix_result = quot_signed;
            fix_exc    = !op.neg && (lo == INT_MIN);
        end else begin
            fix_result = prod_signed[WIDTH-1:0];
            fix_exc    = prod_signed[ACC_W-1:WIDTH] != {WIDTH{prod_signed[WIDTH-1]}};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op      <= '0;
            cnt     <= '0;
            addend  <= '0;
            acc     <= '0;
            dz_pend <= 1'b0;
        end else if (accept) begin
            op      <= '{div: start_div, neg: data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]};
            cnt     <= '0;
            addend  <= start_div ? magnitude(data_operandB) : magnitude(data_operandA);
            acc     <= {{WIDTH{1'b0}}, start_div ? magnitude(data_operandA) : magnitude(data_operandB)};
            dz_pend <= start_dz;
        end else begin
            dz_pend <= 1'b0;
            if (state == RUN && cnt != CNT_W'(ITER_COUNT)) begin
                acc <= acc_step;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= (state_next == DONE);
            busy           <= (state == RUN);
            if (state == FIX) begin
                data_result    <= fix_result;
                data_exception <= fix_exc;
            end else if (state == IDLE && dz_pend) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed table, handshake corner sequences, random ops vs. arithmetic model.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t        vecs[16];
    int          lat, busy_hi, npulse, exp_lat;
    logic        busy_rdy, is_div, exp_exc;
    logic [31:0] a, b, exp_res, got_res;

    multdiv_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Arithmetic reference: true signed result, flagged when it does not fit in 32 bits.
    task automatic model(input logic d, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic e);
        longint sx, sy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (d && y == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else begin
            p = d ? sx / sy : sx * sy;
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h8000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'($urandom_range(0, 1));
            3:       v = 32'($urandom_range(0, 300));
            4:       v = -32'($urandom_range(1, 70000));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic start_op(input logic d, input logic [31:0] x, input logic [31:0] y);
        data_operandA = x;
        data_operandB = y;
        ctrl_MULT     = !d;
        ctrl_DIV      = d;
        tick();
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_ready(output int l, output int bh, output logic br);
        l  = -1;
        bh = 0;
        br = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (data_resultRDY) begin
                l  = k;
                br = busy;
                break;
            end
            if (busy) bh++;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34};
        vecs[1]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 34};
        vecs[2]  = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 34};
        vecs[3]  = '{1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFF2, 1'b0, 34};
        vecs[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34};
        vecs[5]  = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34};
        vecs[7]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 34};
        vecs[8]  = '{1'b1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 34};
        vecs[9]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 34};
        vecs[11] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 34};
        vecs[12] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 34};
        vecs[13] = '{1'b0, 32'hFFFF_8000, 32'h0001_0000, 32'h8000_0000, 1'b0, 34};
        vecs[14] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 1'b0, 34};
        vecs[15] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        tick();
        tick();
        check("reset_result", data_result, 32'h0);
        check("reset_exc", 32'(data_exception), 32'h0);
        check("reset_rdy", 32'(data_resultRDY), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        tick();

        // Directed table, including boundaries and divide-by-zero.
        foreach (vecs[i]) begin
            start_op(vecs[i].is_div, vecs[i].a, vecs[i].b);
            wait_ready(lat, busy_hi, busy_rdy);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), data_result, vecs[i].res);
            check($sformatf("vec%0d_exc", i), 32'(data_exception), 32'(vecs[i].exc));
            check($sformatf("vec%0d_busy_at_rdy", i), 32'(busy_rdy), 32'h0);
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_hi), (vecs[i].lat == 34) ? 32'd33 : 32'd0);
            tick();
            check($sformatf("vec%0d_rdy_pulse", i), 32'(data_resultRDY), 32'h0);
            check($sformatf("vec%0d_result_held", i), data_result, vecs[i].res);
        end

        // DIV pulse during a running MULT is ignored; start in DONE is accepted back-to-back.
        start_op(1'b0, 32'd3, 32'd4);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 10) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd100;
                data_operandB = 32'd7;
            end
            tick();
            ctrl_DIV = 1'b0;
            if (data_resultRDY) begin
                lat = k;
                break;
            end
        end
        check("ignore_div_latency", 32'(lat), 32'd34);
        check("ignore_div_result", data_result, 32'd12);
        check("ignore_div_exc", 32'(data_exception), 32'h0);
        start_op(1'b0, 32'hFFFF_FFFA, 32'd7);
        wait_ready(lat, busy_hi, busy_rdy);
        check("b2b_latency", 32'(lat), 32'd34);
        check("b2b_result", data_result, 32'hFFFF_FFD6);

        // Start held for five cycles yields a single operation.
        data_operandA = 32'd5;
        data_operandB = 32'd6;
        ctrl_MULT     = 1'b1;
        tick();
        npulse  = 0;
        lat     = -1;
        got_res = 32'h0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 5) ctrl_MULT = 1'b0;
            tick();
            if (data_resultRDY) begin
                npulse++;
                if (lat < 0) begin
                    lat     = k;
                    got_res = data_result;
                end
            end
        end
        check("held_latency", 32'(lat), 32'd34);
        check("held_pulses", 32'(npulse), 32'd1);
        check("held_result", got_res, 32'd30);

        // Reset mid-divide: outputs clear at once and the aborted op never reports.
        start_op(1'b1, 32'd1000, 32'd10);
        for (int k = 1; k <= 10; k++) tick();
        check("midrun_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check("rst_result", data_result, 32'h0);
        check("rst_exc", 32'(data_exception), 32'h0);
        check("rst_rdy", 32'(data_resultRDY), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        npulse = 0;
        tick();
        if (data_resultRDY) npulse++;
        tick();
        if (data_resultRDY) npulse++;
        reset_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (data_resultRDY || busy) npulse++;
        end
        check("aborted_no_ready", 32'(npulse), 32'h0);
        start_op(1'b0, 32'd2, 32'd2);
        wait_ready(lat, busy_hi, busy_rdy);
        check("post_rst_latency", 32'(lat), 32'd34);
        check("post_rst_result", data_result, 32'd4);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            is_div = 1'($urandom_range(0, 1));
            a      = pick();
            b      = pick();
            model(is_div, a, b, exp_res, exp_exc);
            exp_lat = (is_div && b == 32'h0) ? 1 : 34;
            start_op(is_div, a, b);
            wait_ready(lat, busy_hi, busy_rdy);
            check($sformatf("rnd%0d_latency op=%0d a=%h b=%h", i, is_div, a, b), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_result op=%0d a=%h b=%h", i, is_div, a, b), data_result, exp_res);
            check($sformatf("rnd%0d_exc op=%0d a=%h b=%h", i, is_div, a, b), 32'(data_exception), 32'(exp_exc));
            if ($urandom_range(0, 1) == 0) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Sequential 32-bit signed multiply/divide unit beside the single-cycle ALU. The ALU's add/sub operand-conditioning path feeds operands forward into one combinational adder. This block is the iterative engine on the other side of that datapath: it consumes one start pulse plus two operands and returns a single result with a ready/exception handshake. It reuses an add/subtract step with operand-B inversion once per iteration: shift-add for multiply, restoring shift-subtract for divide.

## Interface
- No parameters; datapath width fixed at 32.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_operandA  in  32  multiplicand / dividend, two's complement; sampled only on accepted start.
- data_operandB  in  32  multiplier / divisor, two's complement; sampled only on accepted start.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_result  out  32  product low word or quotient; held until the next accepted start.
- data_exception  out  1  overflow or divide-by-zero; valid while data_resultRDY=1.
- data_resultRDY  out  1  one-cycle pulse, result valid.
- busy  out  1  high from the edge after an accepted start until data_resultRDY.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Start acceptance:
  - A start is accepted on an edge where state is IDLE or DONE and ctrl_MULT or ctrl_DIV is 1.
  - If both are 1, MULT wins and DIV is ignored.
  - Starts in RUN or FIX are ignored; no queuing.
- Accept actions:
  - Latch |A| and |B| magnitudes, the result sign (A[31]^B[31]) and the op.
  - Clear the iteration counter (6-bit).
  - Go to RUN.
- Multiply: 32 iterations of unsigned shift-add on magnitudes into a 64-bit accumulator.
- Divide: 32 iterations of restoring division.
  - Each iteration shifts the remainder left and computes remainder − |B| through the shared add/sub step.
  - Keep the difference if non-negative and set the quotient bit; otherwise restore.
- FIX (1 cycle):
  - Negate the result if the sign is 1.
  - Multiply exception = 1 if the 64-bit signed product ≠ sign-extension of its low 32 bits.
  - Divide exception = 1 for 0x80000000 / −1; data_result = 0x80000000 in that case.
- Divide-by-zero: B==0 on an accepted DIV skips RUN/FIX and goes straight to DONE with data_result=0, data_exception=1.
- Arithmetic rules:
  - On multiply overflow, data_result = low 32 bits of the true product.
  - Quotient truncates toward zero; the remainder is not output.
- DONE lasts one cycle:
  - data_resultRDY=1, then IDLE unless a new start is accepted on the same edge.
  - data_result and data_exception keep their values through IDLE.
- Operand changes after acceptance have no effect.

## Timing
- Accepting edge = E0.
- Normal op: RUN on E1..E32, FIX on E33, DONE after E34.
  - data_resultRDY is high for exactly the cycle between E34 and E35.
  - Latency: 34 cycles start-to-ready.
- Divide-by-zero: DONE after E1; latency 1 cycle.
- busy:
  - High after E1 through the cycle before DONE.
  - Low in DONE and IDLE.
  - Not asserted for divide-by-zero.
- Back-to-back: a start sampled in the DONE cycle is accepted; the next ready comes 34 cycles later.
- Reset (reset_n=0), immediate at any time including mid-RUN:
  - State=IDLE, counter=0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - The aborted operation produces no ready.
- ctrl_MULT/ctrl_DIV held high for several cycles produce only one op, the first; the re-sample in DONE starts a second op (documented behaviour).

## Structure
- Shared package holds:
  - state encoding: IDLE=2'b00, RUN=2'b01, FIX=2'b10, DONE=2'b11
  - ITER_COUNT=32
  - WIDTH=32
  - INT_MIN=32'h80000000
- Sub-module multdiv_addsub: a 33-bit add/subtract step with a sub select that inverts B and sets carry-in. One instance serves both multiply (add) and divide (subtract).
- Top holds the FSM, counter and shift registers.

## Test plan
- MULT 7 × −3 (0x00000007, 0xFFFFFFFD) -> data_resultRDY high exactly 34 cycles after start; result 0xFFFFFFEB, exception 0, busy low in the DONE cycle.
- MULT 0x00010000 × 0x00010000 -> result 0x00000000, exception 1; MULT 0x7FFFFFFF × 1 -> 0x7FFFFFFF, exception 0.
- DIV −100 / 7 -> 0xFFFFFFF2 (−14), exception 0; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
- DIV 5 / 0 -> data_resultRDY one cycle after start, result 0, exception 1, busy never high.
- Start MULT 3×4; pulse ctrl_DIV at cycle 10 with different operands -> ignored, single ready at cycle 34 with result 12; new start in the DONE cycle -> second ready 34 cycles later.
- Start DIV 1000/10; drop reset_n at cycle 10 for 2 cycles -> all outputs 0 immediately, no ready pulse; after release, MULT 2×2 -> result 4 at 34 cycles.
